i2s_ctrl: RTL and testbench
===========================

I2S_CTRL -- requirements
Module: i2s_ctrl

Interface
REQ-001 Parameter DW, default 24: sample width per channel.
REQ-002 Parameter SLOT_W, default 32: sclk periods per channel slot; SLOT_W >= DW+1.
REQ-003 Parameter MCLK_DIV, default 4: clk cycles per sclk period; even, >= 4.
REQ-004 Port clk, input, 1 bit: 12.288 MHz audio clock; only clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port en, input, 1 bit: run request (level).
REQ-007 Port mute, input, 1 bit: force zero samples to the transmitter.
REQ-008 Port sclk, output, 1 bit: serial bit clock driven to the i2s interface.
REQ-009 Port lrclk, output, 1 bit: word select; 0 = left, 1 = right.
REQ-010 Port running, output, 1 bit: high when state is not IDLE.
REQ-011 Port tx_rd_en, input, 1 bit: one-cycle sample-pair request from the transmitter.
REQ-012 Ports tx_ldata/tx_rdata, output, DW each: sample pair to the transmitter.
REQ-013 Port tx_rd_valid, output, 1 bit: one-cycle qualifier for tx_ldata/tx_rdata.
REQ-014 Port fifo_rd_en, output, 1 bit: async FIFO read strobe.
REQ-015 Ports fifo_ldata/fifo_rdata, input, DW each: FIFO read data.
REQ-016 Port fifo_valid, input, 1 bit: FIFO data valid, one cycle after fifo_rd_en.
REQ-017 Port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-018 Port underrun_clr, input, 1 bit: clears underrun and underrun_cnt.
REQ-019 Port underrun, output, 1 bit: sticky underrun flag.
REQ-020 Port underrun_cnt, output, 16 bits: saturating underrun count.

Function
REQ-021 States: IDLE, RUN, STOP.
- IDLE: sclk=0, lrclk=1, all counters held at 0.
REQ-022 IDLE with en=1: next cycle enter RUN with lrclk=0, bit_cnt=0, div_cnt=0.
REQ-023 Divider in RUN/STOP:
- div_cnt counts 0..MCLK_DIV/2-1.
- sclk toggles on the terminal count; duty cycle 50%.
REQ-024 Bit counter:
- bit_cnt 0..2*SLOT_W-1, advances on each sclk falling edge (1->0), wraps to 0.
- lrclk = (bit_cnt >= SLOT_W).
- lrclk changes only in the same cycle as sclk falls.
REQ-025 RUN with en=0: enter STOP; timing continues unchanged.
REQ-026 STOP exit on the falling edge where bit_cnt would wrap to 0:
- next state IDLE; lrclk=1, sclk=0.
- No partial frame is ever emitted.
REQ-027 STOP with en=1: return to RUN with no gap or phase change.
REQ-028 tx_rd_en with fifo_empty=0: fifo_rd_en=1 in the same cycle (combinational).
REQ-029 Registered data path:
- tx_ldata/tx_rdata/tx_rd_valid load from fifo_*.
- tx_rd_valid pulses exactly 2 cycles after tx_rd_en.
REQ-030 tx_rd_en with fifo_empty=1:
- fifo_rd_en=0.
- tx_rd_valid pulses 2 cycles later with zero data.
- underrun set; underrun_cnt increments, saturating at 16'hFFFF.
REQ-031 mute=1: FIFO still read normally; delivered data forced to 0; no underrun recorded.
REQ-032 tx_rd_en while IDLE: treated as REQ-028/030 regardless of state.
REQ-033 underrun_clr wins over a same-cycle underrun event; result is flag=0, cnt=0.

Reset
REQ-034 Asynchronous reset on rst_n=0:
- state=IDLE, sclk=0, lrclk=1, running=0.
- tx_rd_valid=0, tx_ldata=0, tx_rdata=0, fifo_rd_en=0.
- underrun=0, underrun_cnt=0.
REQ-035 Reset mid-frame: outputs take reset values immediately; pipelined valids are discarded.

Structure
REQ-036 Shared package i2s_pkg holds:
- state enum i2s_ctrl_state_t {IDLE, RUN, STOP};
- default constants DW=24, SLOT_W=32, MCLK_DIV=4.
REQ-037 One sub-module, i2s_clkgen, owns the divider, bit counter, sclk and lrclk.
- Inputs: clk, rst_n, run.
- Outputs: sclk, lrclk, frame_end.
- The FSM and FIFO arbitration stay in i2s_ctrl.

Verification
REQ-038 Start/stop, defaults: en=1 for 1000 cycles then en=0.
- sclk period 4 clk; lrclk period 256 clk; lrclk low 128 clk.
- Stop completes on a frame boundary; running falls with lrclk=1.
REQ-039 Data flow: FIFO preloaded with (L=24'h123456, R=24'hABCDEF); pulse tx_rd_en.
- fifo_rd_en in the same cycle.
- tx_rd_valid 2 cycles later carrying those values.
REQ-040 Underrun: fifo_empty=1 with 3 tx_rd_en pulses.
- Three zero-data valids; underrun=1; underrun_cnt=3.
- Then underrun_clr -> 0/0.
REQ-041 Cancel stop: en drops mid-frame, rises 50 cycles later.
- sclk/lrclk phase unchanged; running stays 1.
REQ-042 Mute and reset:
- mute=1 with data 24'h7FFFFF -> tx data 0, FIFO still read.
- rst_n low mid-frame -> all outputs at REQ-034 values within the same cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S types and default geometry: channel sample width, slot length and clock divide ratio.
package i2s_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_ctrl_state_t;

  localparam int I2S_DW       = 24;
  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_MCLK_DIV = 4;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator. sclk = clk/MCLK_DIV at 50% duty; lrclk and the bit counter advance on sclk falls.
// Idles at sclk=0/lrclk=1. The first run cycle loads the frame start. frame_end flags the fall that wraps the frame.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int MCLK_DIV = I2S_MCLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic lrclk,
  output logic frame_end
);
  localparam int HALF  = MCLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             act_q, act_d;
  logic             div_term;

  assign div_term  = (div_q == DIV_LAST);
  assign frame_end = act_q && div_term && sclk_q && (bit_q == BIT_LAST);
  assign sclk      = sclk_q;
  assign lrclk     = lrclk_q;

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    lrclk_d = lrclk_q;
    act_d   = act_q;
    if (!run) begin
      div_d   = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      lrclk_d = 1'b1;
      act_d   = 1'b0;
    end else if (!act_q) begin
      // First running cycle: left slot begins without waiting for an sclk fall.
      div_d   = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      lrclk_d = 1'b0;
      act_d   = 1'b1;
    end else if (div_term) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
      if (sclk_q) begin
        bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
        lrclk_d = (bit_d >= SLOT_B);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      act_q   <= act_d;
    end
  end
endmodule

// File: rtl/i2s_ctrl.sv
// I2S controller: run/stop FSM that only stops on frame boundaries, and the FIFO-to-transmitter sample path.
// A tx_rd_en request is answered with a tx_rd_valid pulse 2 cycles later. An empty FIFO yields zero data and counts an underrun.
module i2s_ctrl
  import i2s_pkg::*;
#(
  parameter int DW       = I2S_DW,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int MCLK_DIV = I2S_MCLK_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mute,
  output logic          sclk,
  output logic          lrclk,
  output logic          running,
  input  logic          tx_rd_en,
  output logic [DW-1:0] tx_ldata,
  output logic [DW-1:0] tx_rdata,
  output logic          tx_rd_valid,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_ldata,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_valid,
  input  logic          fifo_empty,
  input  logic          underrun_clr,
  output logic          underrun,
  output logic [15:0]   underrun_cnt
);
  i2s_ctrl_state_t state_q;
  logic            running_q;
  logic            run;
  logic            frame_end;
  logic            req_q, zero_q, vld_q;
  logic [DW-1:0]   ldat_q, rdat_q;
  logic            uf_q;
  logic [15:0]     cnt_q;
  logic            uf_evt;

  // run is the next-cycle "not IDLE" so the clock generator starts and stops on the same edge as the FSM.
  assign run = (state_q == IDLE) ? en : (en || !((state_q == STOP) && frame_end));

  i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .MCLK_DIV(MCLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      running_q <= run;
      case (state_q)
        IDLE:    if (en) state_q <= RUN;
        RUN:     if (!en) state_q <= STOP;
        STOP:    if (en) state_q <= RUN;
                 else if (frame_end) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign running      = running_q;
  assign fifo_rd_en   = rst_n & tx_rd_en & ~fifo_empty;
  assign uf_evt       = tx_rd_en & fifo_empty & ~mute;
  assign tx_ldata     = ldat_q;
  assign tx_rdata     = rdat_q;
  assign tx_rd_valid  = vld_q;
  assign underrun     = uf_q;
  assign underrun_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= 1'b0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
      ldat_q <= '0;
      rdat_q <= '0;
      uf_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      req_q  <= tx_rd_en;
      zero_q <= fifo_empty | mute;
      vld_q  <= req_q;
      if (req_q) begin
        ldat_q <= (zero_q || !fifo_valid) ? '0 : fifo_ldata;
        rdat_q <= (zero_q || !fifo_valid) ? '0 : fifo_rdata;
      end
      if (underrun_clr) begin
        uf_q  <= 1'b0;
        cnt_q <= '0;
      end else if (uf_evt) begin
        uf_q <= 1'b1;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_ctrl.sv
// Self-checking bench for i2s_ctrl: time-based clock model, request/delivery scoreboard, FIFO emulation,
// plus literal checks on frame timing, data flow, underrun, cancel-stop, mute and async reset.
module tb_i2s_ctrl;
  localparam int DW       = 24;
  localparam int SLOT_W   = 32;
  localparam int MCLK_DIV = 4;
  localparam int FRAME    = 2 * SLOT_W * MCLK_DIV;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0, mute = 1'b0, tx_rd_en = 1'b0, underrun_clr = 1'b0;
  logic          sclk, lrclk, running, tx_rd_valid, fifo_rd_en, underrun;
  logic [DW-1:0] tx_ldata, tx_rdata;
  logic [DW-1:0] fifo_ldata = '0, fifo_rdata = '0;
  logic          fifo_valid = 1'b0, fifo_empty = 1'b1;
  logic [15:0]   underrun_cnt;

  int n_chk = 0, n_pass = 0;
  bit chk_on = 0;
  pair_t fq[$];
  logic f_rd;

  always #5 clk = ~clk;

  i2s_ctrl #(.DW(DW), .SLOT_W(SLOT_W), .MCLK_DIV(MCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mute(mute),
    .sclk(sclk), .lrclk(lrclk), .running(running),
    .tx_rd_en(tx_rd_en), .tx_ldata(tx_ldata), .tx_rdata(tx_rdata), .tx_rd_valid(tx_rd_valid),
    .fifo_rd_en(fifo_rd_en), .fifo_ldata(fifo_ldata), .fifo_rdata(fifo_rdata),
    .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
    .underrun_clr(underrun_clr), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    fq.push_back(p);
    fifo_empty = 1'b0;
  endtask

  // FIFO emulation: one-cycle read latency, junk on the data bus when not valid.
  always @(posedge clk) begin
    f_rd = fifo_rd_en;
    #1;
    if (f_rd && fq.size() > 0) begin
      fifo_ldata = fq[0].l;
      fifo_rdata = fq[0].r;
      void'(fq.pop_front());
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
      fifo_ldata = 24'hEEEEEE;
      fifo_rdata = 24'h111111;
    end
    fifo_empty = (fq.size() == 0);
  end

  // Model: m_t counts clk cycles since the run started; a stop lands where the next cycle would open a new frame.
  bit            m_run = 0, m_enp = 0, p1_v = 0, e_v = 0, m_uf = 0;
  int            m_t = 0, m_cnt = 0;
  logic [DW-1:0] p1_l = '0, p1_r = '0, e_l = '0, e_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_enp = 0; m_t = 0;
      p1_v = 0; e_v = 0; e_l = '0; e_r = '0; p1_l = '0; p1_r = '0;
      m_uf = 0; m_cnt = 0;
    end else begin
      if (!m_run) begin
        if (en) begin m_run = 1; m_t = 0; end
      end else if (((m_t + 1) % FRAME) == 0 && !m_enp && !en) m_run = 0;
      else m_t++;
      m_enp = en;
      e_v = p1_v;
      if (p1_v) begin e_l = p1_l; e_r = p1_r; end
      p1_v = tx_rd_en;
      if (tx_rd_en) begin
        if (fifo_empty || mute) begin p1_l = '0; p1_r = '0; end
        else begin p1_l = fq[0].l; p1_r = fq[0].r; end
      end
      if (underrun_clr) begin m_uf = 0; m_cnt = 0; end
      else if (tx_rd_en && fifo_empty && !mute) begin
        m_uf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sclk", 32'(sclk), m_run ? 32'((m_t % MCLK_DIV) >= MCLK_DIV / 2) : 32'd0);
      chk("lrclk", 32'(lrclk), m_run ? 32'((m_t % FRAME) >= SLOT_W * MCLK_DIV) : 32'd1);
      chk("running", 32'(running), 32'(m_run));
      chk("tx_rd_valid", 32'(tx_rd_valid), 32'(e_v));
      if (e_v) begin
        chk("tx_ldata", 32'(tx_ldata), 32'(e_l));
        chk("tx_rdata", 32'(tx_rdata), 32'(e_r));
      end
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(tx_rd_en && !fifo_empty && rst_n));
      chk("underrun", 32'(underrun), 32'(m_uf));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    end
  end

  initial begin
    int f0, r0, f1, s0, s1, k;
    logic pl, ps;
    #1 rst_n = 1'b0;
    #1 chk_on = 1;
    #1;
    chk("rst_running", 32'(running), 0);
    chk("rst_lrclk", 32'(lrclk), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_cnt", 32'(underrun_cnt), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // Start/stop with default geometry.
    f0 = -1; r0 = -1; f1 = -1; s0 = -1; s1 = -1;
    en = 1'b1;
    pl = lrclk; ps = sclk;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (pl && !lrclk) begin if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i; end
      if (!pl && lrclk && r0 < 0) r0 = i;
      if (!ps && sclk) begin if (s0 < 0) s0 = i; else if (s1 < 0) s1 = i; end
      pl = lrclk; ps = sclk;
    end
    chk("start_f0", 32'(f0), 0);
    chk("lrclk_low", 32'(r0 - f0), 128);
    chk("lrclk_period", 32'(f1 - f0), 256);
    chk("sclk_period", 32'(s1 - s0), 4);
    en = 1'b0;
    k = 0;
    while (running && k < 600) begin step(); k++; end
    chk("stop_done", 32'(running), 0);
    chk("stop_lrclk", 32'(lrclk), 1);
    chk("stop_align", 32'((999 + k - f0) % 256), 0);
    repeat (3) step();

    // Data flow, back-to-back, while idle.
    preload(24'h123456, 24'hABCDEF);
    preload(24'h000001, 24'hFFFFFE);
    step(); tx_rd_en = 1'b1; #1 chk("d_rd_en", 32'(fifo_rd_en), 1);
    step(); #1 chk("d_rd_en2", 32'(fifo_rd_en), 1);
    step(); tx_rd_en = 1'b0; #1;
    chk("d_valid", 32'(tx_rd_valid), 1);
    chk("d_ldata", 32'(tx_ldata), 32'h123456);
    chk("d_rdata", 32'(tx_rdata), 32'hABCDEF);
    step(); #1;
    chk("d_ldata2", 32'(tx_ldata), 32'h000001);
    chk("d_rdata2", 32'(tx_rdata), 32'hFFFFFE);
    step(); #1 chk("d_valid_end", 32'(tx_rd_valid), 0);

    // Underrun with an empty FIFO.
    for (int p = 0; p < 3; p++) begin
      step(); tx_rd_en = 1'b1; #1 chk("u_rd_en", 32'(fifo_rd_en), 0);
      step(); tx_rd_en = 1'b0;
    end
    step(); #1;
    chk("u_valid", 32'(tx_rd_valid), 1);
    chk("u_zero", 32'(tx_ldata), 0);
    chk("u_flag", 32'(underrun), 1);
    chk("u_cnt", 32'(underrun_cnt), 3);
    step(); underrun_clr = 1'b1;
    step(); underrun_clr = 1'b0; #1;
    chk("clr_flag", 32'(underrun), 0);
    chk("clr_cnt", 32'(underrun_cnt), 0);
    step(); tx_rd_en = 1'b1; underrun_clr = 1'b1;
    step(); tx_rd_en = 1'b0; underrun_clr = 1'b0; #1;
    chk("clr_wins_flag", 32'(underrun), 0);
    chk("clr_wins_cnt", 32'(underrun_cnt), 0);
    repeat (3) step();

    // Cancel a pending stop mid-frame.
    en = 1'b1;
    for (int i = 0; i < 700; i++) begin
      step();
      if (i == 300) en = 1'b0;
      if (i == 350) en = 1'b1;
      if (i > 300 && i <= 350) chk("cancel_running", 32'(running), 1);
      if (i == 383) chk("cancel_lr_lo", 32'(lrclk), 0);
      if (i == 384) chk("cancel_lr_hi", 32'(lrclk), 1);
    end

    // Mute while running: FIFO still drained, data forced to zero, no underrun.
    mute = 1'b1;
    preload(24'h7FFFFF, 24'h7FFFFF);
    step(); tx_rd_en = 1'b1; #1 chk("m_rd_en", 32'(fifo_rd_en), 1);
    step(); tx_rd_en = 1'b0;
    step(); #1;
    chk("m_valid", 32'(tx_rd_valid), 1);
    chk("m_ldata", 32'(tx_ldata), 0);
    chk("m_rdata", 32'(tx_rdata), 0);
    step(); tx_rd_en = 1'b1;
    step(); tx_rd_en = 1'b0; #1;
    chk("m_no_underrun", 32'(underrun), 0);
    mute = 1'b0;

    // Async reset mid-frame with a request in flight and non-zero state.
    step(); tx_rd_en = 1'b1;
    step(); tx_rd_en = 1'b0;
    preload(24'hAAAAAA, 24'h555555);
    preload(24'h0F0F0F, 24'hF0F0F0);
    preload(24'h333333, 24'h444444);
    step(); tx_rd_en = 1'b1;
    step();
    step(); #1;
    chk("r_pre_valid", 32'(tx_rd_valid), 1);
    chk("r_pre_flag", 32'(underrun), 1);
    rst_n = 1'b0; en = 1'b0; #1;
    chk("r_sclk", 32'(sclk), 0);
    chk("r_lrclk", 32'(lrclk), 1);
    chk("r_running", 32'(running), 0);
    chk("r_valid", 32'(tx_rd_valid), 0);
    chk("r_ldata", 32'(tx_ldata), 0);
    chk("r_rdata", 32'(tx_rdata), 0);
    chk("r_rd_en", 32'(fifo_rd_en), 0);
    chk("r_flag", 32'(underrun), 0);
    chk("r_cnt", 32'(underrun_cnt), 0);
    step(); tx_rd_en = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk_on = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
